hwpe_stream_tcdm_load_source: RTL and testbench
===============================================

Name: hwpe_stream_tcdm_load_source

Overview:
- Upstream producer for hwpe_stream_intf_stream.
- Given a base address, stride and word count, it issues 32-bit TCDM read requests on a hwpe_stream_intf_tcdm master port.
- It buffers r_data responses in a small FIFO and emits them in order as a 32-bit stream on a source port.
- It sits between the cluster TCDM interconnect and an HWPE datapath stream input.

Parameters:
- FIFO_DEPTH, 4, response buffer depth in words. Power of two, >= 2.
- LEN_WIDTH, 16, width of the word-count input.

Ports:
- clk_i  input  1  clock; all logic is rising-edge.
- rst_i  input  1  asynchronous, active-high reset.
- clear_i  input  1  synchronous soft clear; same effect as reset, applied on the clock edge.
- start_i  input  1  one-cycle strobe; sampled only in IDLE.
- base_addr_i  input  32  byte address of the first word; sampled with start_i.
- stride_i  input  32  byte increment between words; sampled with start_i.
- len_i  input  LEN_WIDTH  number of words; sampled with start_i.
- busy_o  output  1  high in any state other than IDLE.
- done_o  output  1  one-cycle pulse at the end of a transfer.
- tcdm  interface  hwpe_stream_intf_tcdm.master  read port: req, add, wen, be, data out; gnt, r_data, r_valid in.
- stream  interface  hwpe_stream_intf_stream.source (DATA_WIDTH=32)  output stream: valid, data, strb out; ready in.

Behaviour:
- Reset/clear values:
  - state=IDLE; busy_o=0, done_o=0.
  - tcdm.req=0, tcdm.add=0; stream.valid=0.
  - FIFO empty; all counters 0.
- Constant outputs:
  - tcdm.wen=1 (read), tcdm.be=4'hF, tcdm.data=0.
  - stream.strb=4'hF.
- States:
  - IDLE -> RUN on start_i with len_i!=0. Latch base, stride and len; issue counter=0.
  - IDLE -> DONE on start_i with len_i==0. No request is issued.
  - RUN -> DRAIN when the last request is granted (issue counter reaches len).
  - DRAIN -> DONE when no response is outstanding, the FIFO is empty, and the last beat has handshaken.
  - DONE -> IDLE unconditionally after one cycle. done_o=1 only in DONE.
- Request issue:
  - tcdm.req=1 in RUN when fifo_count + outstanding < FIFO_DEPTH.
  - A request is granted when req & gnt. Each grant increments the issue counter.
  - The address of word k is base + k*stride, computed incrementally by adding stride after each grant. Arithmetic is modulo 2^32; wrap is silent.
  - Once tcdm.req is asserted, req and add stay stable until gnt. The credit can only grow while a request waits, so req is never retracted.
  - First req appears in the cycle after start_i.
- Responses:
  - TCDM protocol: r_valid arrives exactly one cycle after a granted request. outstanding is therefore 0 or 1.
  - r_valid with outstanding=1 pushes r_data into the FIFO. The credit check guarantees the FIFO is never full on a push.
  - r_valid with outstanding=0 is ignored (protocol violation; flagged by a simulation assertion).
- Stream output:
  - stream.valid = FIFO not empty; stream.data = FIFO head.
  - Pop on valid & ready.
  - Data is stable while valid & !ready; valid is never dropped before the handshake.
  - Push and pop in the same cycle leave the count unchanged.
- Latency with gnt=1 and ready=1:
  - start_i at cycle 0; req at cycles 1..len.
  - First r_valid at cycle 2; first stream.valid at cycle 3.
  - Sustained throughput is one word per cycle.
- start_i while busy_o=1 is ignored.
- Clear with a request in flight:
  - req drops in the next cycle.
  - A drop flag is set if a grant occurred in the cycle clear_i was sampled; the following r_valid is discarded, then the flag clears.
  - The FIFO is flushed, so no stale word ever reaches the stream.
- Asynchronous reset mid-transfer behaves the same as clear; subsequent r_valid is discarded in the same way.

Decomposition:
- Package hwpe_stream_package holds:
  - typedef enum load_state_t {IDLE, RUN, DRAIN, DONE};
  - constants TCDM_BE_ALL=4'hF and TCDM_WEN_READ=1'b1.
- Sub-module hwpe_stream_load_fifo: synchronous FIFO with parameters DEPTH and WIDTH=32.
  - Signals: push, pop, clear, full, empty, count.
  - Includes a registered head-of-line output.
- The top level holds the FSM, address/issue counters, credit logic and the drop flag.

Test Plan:
- base=0x1000, stride=4, len=8, gnt=1, ready=1 -> add=0x1000..0x101C at cycles 1..8; stream.data equals memory words in order at cycles 3..10; done_o pulses one cycle after the last beat.
- Same transfer, ready=0 for cycles 3..12 -> at most 4 requests outstanding or buffered; req stalls; no word is lost or duplicated; all 8 words arrive in order after ready=1.
- gnt toggling with pattern 1,0,0,1 -> add and req stay stable while gnt=0; exactly len grants occur.
- base=0xFFFFFFF8, stride=8, len=3 -> addresses 0xFFFFFFF8, 0x00000000, 0x00000008.
- len=0 -> no req ever asserted; done_o pulses at cycle 1; busy_o high for exactly one cycle.
- clear_i in the cycle of the 3rd grant, len=8 -> the following r_valid is discarded; stream.valid=0 the next cycle; state IDLE; a new start_i runs cleanly.

Source files
------------

// File: rtl/hwpe_stream_tcdm_load_source_pkg.sv
// Shared types and constants for the TCDM load source and its helpers.
package hwpe_stream_package;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } load_state_t;

    localparam logic [3:0] TCDM_BE_ALL   = 4'hF;
    localparam logic       TCDM_WEN_READ = 1'b1;

endpackage

// File: rtl/hwpe_stream_tcdm_load_source_if.sv
// TCDM read/write port and valid/ready stream bundles.
interface hwpe_stream_intf_tcdm;
    logic        req;
    logic        gnt;
    logic [31:0] add;
    logic        wen;
    logic [3:0]  be;
    logic [31:0] data;
    logic [31:0] r_data;
    logic        r_valid;

    modport master (output req, add, wen, be, data, input gnt, r_data, r_valid);
    modport slave  (input req, add, wen, be, data, output gnt, r_data, r_valid);
endinterface

interface hwpe_stream_intf_stream #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                    valid;
    logic                    ready;
    logic [DATA_WIDTH-1:0]   data;
    logic [DATA_WIDTH/8-1:0] strb;

    modport source (output valid, data, strb, input ready);
    modport sink   (input valid, data, strb, output ready);
endinterface

// File: rtl/hwpe_stream_tcdm_load_source_fifo.sv
// Small synchronous FIFO for TCDM read responses with a registered head word.
module hwpe_stream_load_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             push_ok;
    logic [AW-1:0]    rd_ptr_inc;

    // A push into a full FIFO is only legal when a pop frees a slot in the same cycle.
    assign push_ok    = push & (~full | pop);
    assign rd_ptr_inc = rd_ptr_reg + AW'(1);

    // Storage array: write port only, no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers, occupancy and head-of-line register; the head tracks the oldest word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            count_reg <= count_reg + CW'(push_ok) - CW'(pop);
            if (pop) begin
                if (count_reg > CW'(1)) begin
                    head_reg <= mem[rd_ptr_inc];
                end else if (push_ok) begin
                    head_reg <= push_data;
                end
            end else if (push_ok && count_reg == '0) begin
                head_reg <= push_data;
            end
        end
    end

    assign head  = head_reg;
    assign count = count_reg;
    assign empty = (count_reg == '0);
    assign full  = (count_reg == CW'(DEPTH));

endmodule

// File: rtl/hwpe_stream_tcdm_load_source.sv
// Strided TCDM reader: issues word reads and replays responses as an in-order stream.
module hwpe_stream_tcdm_load_source
    import hwpe_stream_package::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   start_i,
    input  logic [31:0]            base_addr_i,
    input  logic [31:0]            stride_i,
    input  logic [LEN_WIDTH-1:0]   len_i,
    output logic                   busy_o,
    output logic                   done_o,
    hwpe_stream_intf_tcdm.master   tcdm,
    hwpe_stream_intf_stream.source stream
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W = CNT_W + 1;

    load_state_t          state_reg;
    load_state_t          state_next;
    logic [LEN_WIDTH-1:0] len_reg;
    logic [LEN_WIDTH-1:0] issue_reg;
    logic [LEN_WIDTH-1:0] issue_next;
    logic [31:0]          stride_reg;
    logic [31:0]          add_reg;
    logic                 req_reg;
    logic                 req_next;
    logic                 outstanding_reg;
    logic                 drop_reg;
    logic                 busy_reg;
    logic                 done_reg;

    logic                 grant;
    logic                 push;
    logic                 pop;
    logic [OCC_W-1:0]     occ_next;
    logic [31:0]          fifo_head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    hwpe_stream_load_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) i_fifo (
        .clk       (clk_i),
        .rst       (rst_i),
        .clear     (clear_i),
        .push      (push),
        .push_data (tcdm.r_data),
        .pop       (pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next-state, credit and handshake decode. The credit counts buffered words plus the
    // word that will be in flight next cycle, so a waiting request never loses its credit.
    always_comb begin
        grant      = req_reg & tcdm.gnt;
        push       = tcdm.r_valid & outstanding_reg & ~drop_reg;
        pop        = ~fifo_empty & stream.ready;
        issue_next = issue_reg + LEN_WIDTH'(grant);
        occ_next   = OCC_W'(fifo_count) + OCC_W'(push) + OCC_W'(grant) - OCC_W'(pop);
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = (len_i != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (grant && issue_next == len_reg) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!outstanding_reg &&
                    (fifo_empty || (fifo_count == CNT_W'(1) && pop))) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        req_next = (state_next == RUN) && (occ_next < OCC_W'(FIFO_DEPTH));
    end

    // FSM, address/issue counters and drop flag; all outputs are registered here.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            len_reg         <= '0;
            issue_reg       <= '0;
            stride_reg      <= '0;
            add_reg         <= '0;
            req_reg         <= 1'b0;
            outstanding_reg <= 1'b0;
            drop_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else if (clear_i) begin
            state_reg       <= IDLE;
            len_reg         <= '0;
            issue_reg       <= '0;
            stride_reg      <= '0;
            add_reg         <= '0;
            req_reg         <= 1'b0;
            outstanding_reg <= 1'b0;
            // A grant in the clearing cycle still produces a response next cycle; swallow it.
            drop_reg        <= grant;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            busy_reg        <= (state_next != IDLE);
            done_reg        <= (state_next == DONE);
            req_reg         <= req_next;
            outstanding_reg <= grant;
            if (drop_reg && tcdm.r_valid) begin
                drop_reg <= 1'b0;
            end
            if (state_reg == IDLE && start_i) begin
                len_reg    <= len_i;
                stride_reg <= stride_i;
                add_reg    <= base_addr_i;
                issue_reg  <= '0;
            end else if (grant) begin
                issue_reg <= issue_next;
                add_reg   <= add_reg + stride_reg;
            end
        end
    end

    assign tcdm.req     = req_reg;
    assign tcdm.add     = add_reg;
    assign tcdm.wen     = TCDM_WEN_READ;
    assign tcdm.be      = TCDM_BE_ALL;
    assign tcdm.data    = '0;
    assign stream.valid = ~fifo_empty;
    assign stream.data  = fifo_head;
    assign stream.strb  = 4'hF;
    assign busy_o       = busy_reg;
    assign done_o       = done_reg;

    // A response with nothing in flight is a slave protocol violation.
    r_valid_expected: assert property (@(posedge clk_i) disable iff (rst_i)
        tcdm.r_valid |-> (outstanding_reg || drop_reg));

    // The credit check must keep the FIFO from overflowing.
    push_has_room: assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> (!fifo_full || pop));

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_source.sv
// Directed testbench for the TCDM load source with a one-cycle-latency TCDM slave model.
module tb_hwpe_stream_tcdm_load_source;
    logic        clk = 1'b0;
    logic        rst;
    logic        clear_i;
    logic        start_i;
    logic [31:0] base_addr_i;
    logic [31:0] stride_i;
    logic [15:0] len_i;
    logic        busy_o;
    logic        done_o;

    hwpe_stream_intf_tcdm tcdm ();
    hwpe_stream_intf_stream #(.DATA_WIDTH(32)) stream ();

    hwpe_stream_tcdm_load_source #(
        .FIFO_DEPTH (4),
        .LEN_WIDTH  (16)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_i     (clear_i),
        .start_i     (start_i),
        .base_addr_i (base_addr_i),
        .stride_i    (stride_i),
        .len_i       (len_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .tcdm        (tcdm),
        .stream      (stream)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // TCDM slave: response exactly one cycle after each granted request.
    always @(posedge clk) begin
        tcdm.r_valid <= tcdm.req & tcdm.gnt;
        tcdm.r_data  <= memf(tcdm.add);
    end

    int passed = 0;
    int total  = 0;

    // Monitor state
    bit          mon_en = 1'b0;
    int          t0 = 0;
    logic [31:0] add_q [$];
    int          gcyc_q [$];
    logic [31:0] beat_q [$];
    int          bcyc_q [$];
    int          done_q [$];
    int          gcount, bcount, req_cnt, busy_cnt, max_occ;
    int          req_unstable, valid_unstable;
    bit          p_req, p_gnt, p_valid, p_ready;
    logic [31:0] p_add, p_data;
    bit          valid_hist [64];
    bit          busy_hist [64];
    bit          req_hist [64];

    initial begin
        int rel;
        int occ;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                rel = cyc - t0;
                occ = gcount - bcount;
                if (occ > max_occ) max_occ = occ;
                if (rel >= 0 && rel < 64) begin
                    valid_hist[rel] = stream.valid;
                    busy_hist[rel]  = busy_o;
                    req_hist[rel]   = tcdm.req;
                end
                if (tcdm.req && tcdm.gnt) begin
                    add_q.push_back(tcdm.add);
                    gcyc_q.push_back(rel);
                    gcount++;
                end
                if (stream.valid && stream.ready) begin
                    beat_q.push_back(stream.data);
                    bcyc_q.push_back(rel);
                    bcount++;
                end
                if (tcdm.req) req_cnt++;
                if (busy_o) busy_cnt++;
                if (done_o) done_q.push_back(rel);
                if (p_req && !p_gnt && (tcdm.req !== 1'b1 || tcdm.add !== p_add)) req_unstable++;
                if (p_valid && !p_ready && (stream.valid !== 1'b1 || stream.data !== p_data)) valid_unstable++;
                p_req   = tcdm.req;
                p_gnt   = tcdm.gnt;
                p_add   = tcdm.add;
                p_valid = stream.valid;
                p_ready = stream.ready;
                p_data  = stream.data;
            end
        end
    end

    function automatic bit gpat(input int n);
        case ((n - 1) % 4)
            0, 3:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Drives one transfer for a fixed number of cycles and lets the monitor collect events.
    task automatic run_xfer(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] len,
                            input bit gtoggle, input int rlo_s, input int rlo_e,
                            input int clr_at, input int busy_start_at, input int ncyc);
        add_q.delete(); gcyc_q.delete(); beat_q.delete(); bcyc_q.delete(); done_q.delete();
        gcount = 0; bcount = 0; req_cnt = 0; busy_cnt = 0; max_occ = 0;
        req_unstable = 0; valid_unstable = 0;
        p_req = 1'b0; p_gnt = 1'b0; p_valid = 1'b0; p_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            valid_hist[i] = 1'b0; busy_hist[i] = 1'b0; req_hist[i] = 1'b0;
        end
        @(posedge clk); #1;
        t0 = cyc;
        start_i = 1'b1; base_addr_i = base; stride_i = stride; len_i = len;
        tcdm.gnt = 1'b1;
        stream.ready = !(0 >= rlo_s && 0 <= rlo_e);
        mon_en = 1'b1;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk); #1;
            start_i = (n == busy_start_at);
            if (n == busy_start_at) begin
                base_addr_i = 32'hDEAD0000; len_i = 16'd5;
            end
            clear_i = (n == clr_at);
            tcdm.gnt = gtoggle ? gpat(n) : 1'b1;
            stream.ready = !(n >= rlo_s && n <= rlo_e);
        end
        @(posedge clk); #1;
        mon_en = 1'b0; start_i = 1'b0; clear_i = 1'b0; tcdm.gnt = 1'b1; stream.ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy_o); else passed++;
        total++; if (done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", done_o); else passed++;
        total++; if (tcdm.req !== 1'b0) $display("FAIL reset_req: got %b want 0", tcdm.req); else passed++;
        total++; if (tcdm.add !== 32'h0) $display("FAIL reset_add: got %h want 0", tcdm.add); else passed++;
        total++; if (stream.valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", stream.valid); else passed++;
        total++; if (tcdm.wen !== 1'b1) $display("FAIL const_wen: got %b want 1", tcdm.wen); else passed++;
        total++; if (tcdm.be !== 4'hF) $display("FAIL const_be: got %h want f", tcdm.be); else passed++;
        total++; if (tcdm.data !== 32'h0) $display("FAIL const_wdata: got %h want 0", tcdm.data); else passed++;
        total++; if (stream.strb !== 4'hF) $display("FAIL const_strb: got %h want f", stream.strb); else passed++;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++; if (busy_o !== 1'b0) $display("FAIL post_reset_busy: got %b want 0", busy_o); else passed++;
        total++; if (tcdm.req !== 1'b0) $display("FAIL post_reset_req: got %b want 0", tcdm.req); else passed++;
    endtask

    task automatic test_basic();
        logic [31:0] ga, gd;
        int gc;
        $display("basic: base=0x1000 stride=4 len=8, extra start while busy");
        run_xfer(32'h1000, 32'd4, 16'd8, 1'b0, -1, -1, -1, 5, 16);
        total++; if (gcount != 8) $display("FAIL basic_grants: got %0d want 8", gcount); else passed++;
        for (int k = 0; k < 8; k++) begin
            ga = (k < add_q.size()) ? add_q[k] : 32'hxxxxxxxx;
            gc = (k < gcyc_q.size()) ? gcyc_q[k] : -1;
            total++; if (ga !== 32'h1000 + 32'(4 * k)) $display("FAIL basic_add[%0d]: got %h want %h", k, ga, 32'h1000 + 32'(4 * k)); else passed++;
            total++; if (gc != k + 1) $display("FAIL basic_req_cycle[%0d]: got %0d want %0d", k, gc, k + 1); else passed++;
        end
        total++; if (bcount != 8) $display("FAIL basic_beats: got %0d want 8", bcount); else passed++;
        for (int k = 0; k < 8; k++) begin
            gd = (k < beat_q.size()) ? beat_q[k] : 32'hxxxxxxxx;
            gc = (k < bcyc_q.size()) ? bcyc_q[k] : -1;
            total++; if (gd !== memf(32'h1000 + 32'(4 * k))) $display("FAIL basic_data[%0d]: got %h want %h", k, gd, memf(32'h1000 + 32'(4 * k))); else passed++;
            total++; if (gc != k + 3) $display("FAIL basic_beat_cycle[%0d]: got %0d want %0d", k, gc, k + 3); else passed++;
        end
        gc = (done_q.size() > 0) ? done_q[0] : -1;
        total++; if (done_q.size() != 1 || gc != 11) $display("FAIL basic_done: got %0d pulses first at %0d want 1 at 11", done_q.size(), gc); else passed++;
        total++; if (busy_cnt != 11) $display("FAIL basic_busy_cycles: got %0d want 11", busy_cnt); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] gd;
        int early, gc;
        $display("backpressure: ready low for cycles 3..12");
        run_xfer(32'h1000, 32'd4, 16'd8, 1'b0, 3, 12, -1, -1, 30);
        early = 0;
        foreach (gcyc_q[i]) if (gcyc_q[i] <= 12) early++;
        total++; if (early != 4) $display("FAIL bp_grants_during_stall: got %0d want 4", early); else passed++;
        total++; if (max_occ > 4) $display("FAIL bp_max_occupancy: got %0d want <=4", max_occ); else passed++;
        total++; if (valid_unstable != 0) $display("FAIL bp_valid_stable: got %0d violations want 0", valid_unstable); else passed++;
        total++; if (bcount != 8) $display("FAIL bp_beats: got %0d want 8", bcount); else passed++;
        for (int k = 0; k < 8; k++) begin
            gd = (k < beat_q.size()) ? beat_q[k] : 32'hxxxxxxxx;
            total++; if (gd !== memf(32'h1000 + 32'(4 * k))) $display("FAIL bp_data[%0d]: got %h want %h", k, gd, memf(32'h1000 + 32'(4 * k))); else passed++;
        end
        gc = (bcyc_q.size() > 0) ? bcyc_q[0] : -1;
        total++; if (gc != 13) $display("FAIL bp_first_beat_cycle: got %0d want 13", gc); else passed++;
        gc = (done_q.size() > 0) ? done_q[0] : -1;
        total++; if (done_q.size() != 1 || gc != 21) $display("FAIL bp_done: got %0d pulses first at %0d want 1 at 21", done_q.size(), gc); else passed++;
    endtask

    task automatic test_gnt_toggle();
        int exp_gc [4] = '{1, 4, 5, 8};
        logic [31:0] ga, gd;
        int gc;
        $display("gnt toggle: pattern 1,0,0,1 len=4");
        run_xfer(32'h2000, 32'h10, 16'd4, 1'b1, -1, -1, -1, -1, 20);
        total++; if (gcount != 4) $display("FAIL gt_grants: got %0d want 4", gcount); else passed++;
        total++; if (req_unstable != 0) $display("FAIL gt_req_stable: got %0d violations want 0", req_unstable); else passed++;
        for (int k = 0; k < 4; k++) begin
            ga = (k < add_q.size()) ? add_q[k] : 32'hxxxxxxxx;
            gc = (k < gcyc_q.size()) ? gcyc_q[k] : -1;
            gd = (k < beat_q.size()) ? beat_q[k] : 32'hxxxxxxxx;
            total++; if (ga !== 32'h2000 + 32'(16 * k)) $display("FAIL gt_add[%0d]: got %h want %h", k, ga, 32'h2000 + 32'(16 * k)); else passed++;
            total++; if (gc != exp_gc[k]) $display("FAIL gt_grant_cycle[%0d]: got %0d want %0d", k, gc, exp_gc[k]); else passed++;
            total++; if (gd !== memf(32'h2000 + 32'(16 * k))) $display("FAIL gt_data[%0d]: got %h want %h", k, gd, memf(32'h2000 + 32'(16 * k))); else passed++;
        end
        gc = (done_q.size() > 0) ? done_q[0] : -1;
        total++; if (done_q.size() != 1 || gc != 11) $display("FAIL gt_done: got %0d pulses first at %0d want 1 at 11", done_q.size(), gc); else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [3] = '{32'hFFFFFFF8, 32'h00000000, 32'h00000008};
        logic [31:0] ga, gd;
        $display("wrap: base=0xFFFFFFF8 stride=8 len=3");
        run_xfer(32'hFFFFFFF8, 32'd8, 16'd3, 1'b0, -1, -1, -1, -1, 12);
        total++; if (gcount != 3) $display("FAIL wrap_grants: got %0d want 3", gcount); else passed++;
        for (int k = 0; k < 3; k++) begin
            ga = (k < add_q.size()) ? add_q[k] : 32'hxxxxxxxx;
            gd = (k < beat_q.size()) ? beat_q[k] : 32'hxxxxxxxx;
            total++; if (ga !== exp_a[k]) $display("FAIL wrap_add[%0d]: got %h want %h", k, ga, exp_a[k]); else passed++;
            total++; if (gd !== memf(exp_a[k])) $display("FAIL wrap_data[%0d]: got %h want %h", k, gd, memf(exp_a[k])); else passed++;
        end
    endtask

    task automatic test_zero_len();
        int gc;
        $display("zero length transfer");
        run_xfer(32'h5000, 32'd4, 16'd0, 1'b0, -1, -1, -1, -1, 6);
        total++; if (req_cnt != 0) $display("FAIL zl_req_cycles: got %0d want 0", req_cnt); else passed++;
        total++; if (bcount != 0) $display("FAIL zl_beats: got %0d want 0", bcount); else passed++;
        gc = (done_q.size() > 0) ? done_q[0] : -1;
        total++; if (done_q.size() != 1 || gc != 1) $display("FAIL zl_done: got %0d pulses first at %0d want 1 at 1", done_q.size(), gc); else passed++;
        total++; if (busy_cnt != 1) $display("FAIL zl_busy_cycles: got %0d want 1", busy_cnt); else passed++;
    endtask

    task automatic test_clear();
        logic [31:0] gd;
        int gc;
        $display("clear in the cycle of the 3rd grant, then restart");
        run_xfer(32'h3000, 32'd4, 16'd8, 1'b0, -1, -1, 3, -1, 6);
        total++; if (gcount != 3) $display("FAIL clr_grants: got %0d want 3", gcount); else passed++;
        total++; if (bcount != 1) $display("FAIL clr_beats: got %0d want 1", bcount); else passed++;
        gd = (beat_q.size() > 0) ? beat_q[0] : 32'hxxxxxxxx;
        total++; if (gd !== memf(32'h3000)) $display("FAIL clr_first_data: got %h want %h", gd, memf(32'h3000)); else passed++;
        total++; if (valid_hist[4] !== 1'b0) $display("FAIL clr_valid_c4: got %b want 0", valid_hist[4]); else passed++;
        total++; if (valid_hist[5] !== 1'b0) $display("FAIL clr_valid_c5: got %b want 0", valid_hist[5]); else passed++;
        total++; if (busy_hist[4] !== 1'b0) $display("FAIL clr_busy_c4: got %b want 0", busy_hist[4]); else passed++;
        total++; if (req_hist[4] !== 1'b0) $display("FAIL clr_req_c4: got %b want 0", req_hist[4]); else passed++;
        total++; if (done_q.size() != 0) $display("FAIL clr_no_done: got %0d pulses want 0", done_q.size()); else passed++;
        run_xfer(32'h4000, 32'd4, 16'd2, 1'b0, -1, -1, -1, -1, 10);
        total++; if (bcount != 2) $display("FAIL clr_restart_beats: got %0d want 2", bcount); else passed++;
        for (int k = 0; k < 2; k++) begin
            gd = (k < beat_q.size()) ? beat_q[k] : 32'hxxxxxxxx;
            total++; if (gd !== memf(32'h4000 + 32'(4 * k))) $display("FAIL clr_restart_data[%0d]: got %h want %h", k, gd, memf(32'h4000 + 32'(4 * k))); else passed++;
        end
        gc = (done_q.size() > 0) ? done_q[0] : -1;
        total++; if (done_q.size() != 1 || gc != 5) $display("FAIL clr_restart_done: got %0d pulses first at %0d want 1 at 5", done_q.size(), gc); else passed++;
    endtask

    initial begin
        rst = 1'b1; clear_i = 1'b0; start_i = 1'b0;
        base_addr_i = '0; stride_i = '0; len_i = '0;
        tcdm.gnt = 1'b1; stream.ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_gnt_toggle();
        test_wrap();
        test_zero_len();
        test_clear();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
